// File: rtl/rega_cycle_ctrl_if.sv
// Irrigation-cycle controller bus: sensor, request and outlet-control signals.
// Optional macro REGA_MANUAL_OVERRIDE_EN adds the manual valve override input.
interface rega_cycle_ctrl_if;
  logic       start;
  logic       dry;
  logic       tank_low;
  logic       mode;
`ifdef REGA_MANUAL_OVERRIDE_EN
  logic       manual;
`endif
  logic       valve;
  logic       sel;
  logic       busy;
  logic       fault;
  logic [3:0] reps_done;

  // Drives requests/sensors, observes the controller outputs.
  modport master (
    output start, dry, tank_low, mode,
`ifdef REGA_MANUAL_OVERRIDE_EN
    output manual,
`endif
    input  valve, sel, busy, fault, reps_done
  );

  // The controller itself.
  modport slave (
    input  start, dry, tank_low, mode,
`ifdef REGA_MANUAL_OVERRIDE_EN
    input  manual,
`endif
    output valve, sel, busy, fault, reps_done
  );
endinterface

// File: rtl/rega_cycle_ctrl.sv
// Irrigation-cycle controller: debounces the dryness sensor, runs timed
// irrigate/soak repetitions and latches the outlet mux select per cycle.
// Optional macro REGA_MANUAL_OVERRIDE_EN: combinational manual valve override,
// gated off by an empty tank or a reservoir fault.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | waiting for start with debounced dry soil
//  S_IRRIGATE| valve open, timer counts down IRR_CYCLES
//  S_SOAK    | valve closed, timer counts down SOAK_CYCLES
//  S_FAULT   | reservoir empty; waits for tank_low=0 and start=0
module rega_cycle_ctrl #(
  parameter int DEB_CYCLES  = 3,
  parameter int IRR_CYCLES  = 8,
  parameter int SOAK_CYCLES = 4,
  parameter int MAX_REPS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rega_cycle_ctrl_if.slave  bus
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int MAXC   = (IRR_CYCLES > SOAK_CYCLES) ? IRR_CYCLES : SOAK_CYCLES;
  localparam int TW     = $clog2(MAXC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]    IRR_LAST  = TW'(IRR_CYCLES - 1);
  localparam logic [TW-1:0]    SOAK_LAST = TW'(SOAK_CYCLES - 1);
  localparam logic [3:0]       REPS_MAX  = 4'(MAX_REPS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IRRIGATE = 2'd1,
    S_SOAK     = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [3:0]       reps_q;
  logic             valve_q;
  logic             sel_q;
  logic             busy_q;
  logic             fault_q;

  logic             dry_db_q, dry_db_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Debounce: dry_db follows dry only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    dry_db_d  = dry_db_q;
    deb_cnt_d = '0;
    if (bus.dry != dry_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        dry_db_d  = bus.dry;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dry_db_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      dry_db_q  <= dry_db_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Cycle sequencer with registered outputs; FSM decisions use the current dry_db.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      reps_q  <= 4'd0;
      valve_q <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.tank_low) begin
            state_q <= S_FAULT;
            busy_q  <= 1'b1;
            fault_q <= 1'b1;
          end else if (bus.start && dry_db_q) begin
            state_q <= S_IRRIGATE;
            busy_q  <= 1'b1;
            valve_q <= 1'b1;
            sel_q   <= bus.mode;
            timer_q <= IRR_LAST;
            reps_q  <= 4'd0;
          end
        end
        S_IRRIGATE: begin
          if (bus.tank_low) begin
            state_q <= S_FAULT;
            valve_q <= 1'b0;
            fault_q <= 1'b1;
          end else if (timer_q == '0) begin
            state_q <= S_SOAK;
            valve_q <= 1'b0;
            timer_q <= SOAK_LAST;
            reps_q  <= reps_q + 4'd1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_SOAK: begin
          if (timer_q == '0) begin
            if (dry_db_q && (reps_q < REPS_MAX)) begin
              state_q <= S_IRRIGATE;
              valve_q <= 1'b1;
              timer_q <= IRR_LAST;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_FAULT: begin
          if (!bus.tank_low && !bus.start) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valve_q <= 1'b0;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.reps_done = reps_q;

`ifdef REGA_MANUAL_OVERRIDE_EN
  // Override never opens the valve on an empty tank or while faulted.
  assign bus.valve = valve_q | (bus.manual & ~bus.tank_low & ~fault_q);
`else
  assign bus.valve = valve_q;
`endif

endmodule

// File: tb/tb_rega_cycle_ctrl.sv
// Testbench for rega_cycle_ctrl: directed scenarios plus randomized traffic,
// checked against a phase/elapsed-time reference model.
module tb_rega_cycle_ctrl;

  localparam int DEB  = 3;
  localparam int IRR  = 8;
  localparam int SOAK = 4;
  localparam int MAXR = 2;

  logic clk;
  logic rst_n;
  rega_cycle_ctrl_if bus_if();

  rega_cycle_ctrl #(
    .DEB_CYCLES(DEB), .IRR_CYCLES(IRR), .SOAK_CYCLES(SOAK), .MAX_REPS(MAXR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: phase 0 idle, 1 watering, 2 resting, 3 alarm.
  int m_phase;
  int m_elapsed;
  int m_done;
  int m_outlet;
  int m_filt;
  int m_run;
  int m_manual;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int s, input int d, input int t, input int m, input int r);
    int old_filt;
    if (r == 0) begin
      m_phase = 0; m_elapsed = 0; m_done = 0; m_outlet = 0; m_filt = 0; m_run = 0;
      return;
    end
    old_filt = m_filt;
    if (d != m_filt) begin
      m_run++;
      if (m_run == DEB) begin m_filt = d; m_run = 0; end
    end else m_run = 0;
    case (m_phase)
      0: if (s == 1 && t == 1) m_phase = 3;
         else if (s == 1 && old_filt == 1) begin
           m_phase = 1; m_elapsed = 0; m_done = 0; m_outlet = m;
         end
      1: if (t == 1) m_phase = 3;
         else if (m_elapsed == IRR - 1) begin m_phase = 2; m_elapsed = 0; m_done++; end
         else m_elapsed++;
      2: if (m_elapsed == SOAK - 1) begin
           if (old_filt == 1 && m_done < MAXR) begin m_phase = 1; m_elapsed = 0; end
           else m_phase = 0;
         end else m_elapsed++;
      default: if (t == 0 && s == 0) m_phase = 0;
    endcase
  endtask

  function automatic int exp_valve(input int t);
    int v;
    v = (m_phase == 1) ? 1 : 0;
`ifdef REGA_MANUAL_OVERRIDE_EN
    if (m_manual == 1 && t == 0 && m_phase != 3) v = 1;
`endif
    return v;
  endfunction

  task automatic check_outputs(input int t);
    chk("valve", 8'(bus_if.valve), 8'(exp_valve(t)));
    chk("sel",   8'(bus_if.sel),   8'(m_outlet));
    chk("busy",  8'(bus_if.busy),  8'(m_phase != 0));
    chk("fault", 8'(bus_if.fault), 8'(m_phase == 3));
    chk("reps",  8'(bus_if.reps_done), 8'(m_done));
  endtask

  // Apply inputs, clock one edge, advance the model and compare outputs.
  task automatic step(input int s, input int d, input int t, input int m, input int r);
    bus_if.start    = s[0];
    bus_if.dry      = d[0];
    bus_if.tank_low = t[0];
    bus_if.mode     = m[0];
    rst_n           = r[0];
`ifdef REGA_MANUAL_OVERRIDE_EN
    bus_if.manual   = m_manual[0];
`endif
    @(posedge clk);
    model_step(s, d, t, m, r);
    #1;
    check_outputs(t);
  endtask

  int vcount;
  int s_r, d_r, t_r, m_r, r_r;

  initial begin
    n_cmp = 0; n_err = 0; m_manual = 0;
    m_phase = 0; m_elapsed = 0; m_done = 0; m_outlet = 0; m_filt = 0; m_run = 0;
    bus_if.start = 0; bus_if.dry = 0; bus_if.tank_low = 0; bus_if.mode = 0; rst_n = 0;
`ifdef REGA_MANUAL_OVERRIDE_EN
    bus_if.manual = 0;
`endif
    @(posedge clk); #1;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++)
      step($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1), 0);

    // Full two-repetition sprinkler cycle.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 1, 1);
    vcount = 1;
    for (int i = 0; i < 25; i++) begin
      step(0, 1, 0, 0, 1);
      if (bus_if.valve) vcount++;
    end
    chk("t2_valve_cycles", 8'(vcount), 8'd16);
    chk("t2_busy_end", 8'(bus_if.busy), 8'd0);
    chk("t2_reps_end", 8'(bus_if.reps_done), 8'd2);
    chk("t2_sel_end",  8'(bus_if.sel), 8'd1);

    // Reservoir runs dry on the third irrigate cycle.
    step(1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("t3_fault_set", 8'(bus_if.fault), 8'd1);
    chk("t3_valve_off", 8'(bus_if.valve), 8'd0);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("t3_fault_hold", 8'(bus_if.fault), 8'd1);
    step(0, 1, 0, 0, 1);
    chk("t3_fault_clr", 8'(bus_if.fault), 8'd0);
    chk("t3_reps_held", 8'(bus_if.reps_done), 8'd0);

    // Short dry glitch never reaches the FSM.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("t4_busy", 8'(bus_if.busy), 8'd0);
    chk("t4_valve", 8'(bus_if.valve), 8'd0);

    // Reset mid-irrigation, then a fresh full window.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    chk("t5_valve_rst", 8'(bus_if.valve), 8'd0);
    chk("t5_busy_rst", 8'(bus_if.busy), 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    vcount = 1;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 0, 1);
      if (bus_if.valve) vcount++;
    end
    chk("t5_window", 8'(vcount), 8'd8);

`ifdef REGA_MANUAL_OVERRIDE_EN
    // Manual override in idle follows tank_low combinationally.
    step(0, 0, 0, 0, 0);
    m_manual = 1;
    bus_if.manual = 1'b1;
    #1;
    chk("t6_manual_on", 8'(bus_if.valve), 8'd1);
    bus_if.tank_low = 1'b1;
    #1;
    chk("t6_manual_tank", 8'(bus_if.valve), 8'd0);
    bus_if.tank_low = 1'b0;
    m_manual = 0;
`endif

    // Randomized traffic.
    s_r = 0; d_r = 0; t_r = 0; m_r = 0;
    for (int i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(3) == 0) ? 1 : 0;
      if ($urandom_range(7) == 0) d_r = 1 - d_r;
      if ($urandom_range(19) == 0) t_r = 1 - t_r;
      m_r = $urandom_range(1);
      r_r = ($urandom_range(199) == 0) ? 0 : 1;
`ifdef REGA_MANUAL_OVERRIDE_EN
      m_manual = ($urandom_range(7) == 0) ? 1 : 0;
`endif
      step(s_r, d_r, t_r, m_r, r_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
